// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the arbitrated ALU controller: ALU mode codes
// and the controller FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_NOT = 3'b101;
    localparam logic [2:0] MODE_INC = 3'b110;
    localparam logic [2:0] MODE_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_ctrl_alu.sv
// Shared n-bit combinational ALU (module ALU_n_bit); cb is carry for
// add/inc and borrow for sub/dec, zero for logic ops.
module ALU_n_bit
    import alu_ctrl_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [2:0]   mode,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] result,
    output logic         cb
);

    logic [n:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        cb     = 1'b0;
        case (mode)
            MODE_ADD: begin
                wide   = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
                result = wide[n-1:0];
                cb     = wide[n];
            end
            // Borrow appears as the sign bit of the widened difference
            MODE_SUB: begin
                wide   = {1'b0, a} - {1'b0, b} - {{n{1'b0}}, cin};
                result = wide[n-1:0];
                cb     = wide[n];
            end
            MODE_AND: result = a & b;
            MODE_OR:  result = a | b;
            MODE_XOR: result = a ^ b;
            MODE_NOT: result = ~a;
            MODE_INC: begin
                wide   = {1'b0, a} + {{n{1'b0}}, 1'b1};
                result = wide[n-1:0];
                cb     = wide[n];
            end
            default: begin
                wide   = {1'b0, a} - {{n{1'b0}}, 1'b1};
                result = wide[n-1:0];
                cb     = wide[n];
            end
        endcase
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin front end for a shared ALU_n_bit datapath.
// Define ALU_ARB_CTRL_ZERO_FLAG_EN to add the registered rsp_zero output.
module alu_arb_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_mode,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req0_chain,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_mode,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    input  logic         req1_cin,
    input  logic         req1_chain,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [n-1:0] rsp_result,
    output logic         rsp_cb,
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
    output logic         rsp_zero,
`endif
    output logic         busy
);

    state_t       state;
    logic         last;
    logic [1:0]   carry_flag;
    logic [2:0]   op_mode;
    logic [n-1:0] op_a;
    logic [n-1:0] op_b;
    logic         op_cin;
    logic         op_id;
    logic         grant;
    logic         hs;
    logic         arith;
    logic [n-1:0] alu_result;
    logic         alu_cb;

    // Contended grant goes to whoever did not win last time
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last;
        else
            grant = req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign hs         = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    assign arith = (op_mode == MODE_ADD) || (op_mode == MODE_SUB) ||
                   (op_mode == MODE_INC) || (op_mode == MODE_DEC);

    ALU_n_bit #(.n(n)) u_alu (
        .mode   (op_mode),
        .a      (op_a),
        .b      (op_b),
        .cin    (op_cin),
        .result (alu_result),
        .cb     (alu_cb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            carry_flag <= 2'b00;
            op_mode    <= MODE_ADD;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_cb     <= 1'b0;
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
            rsp_zero   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        op_mode <= grant ? req1_mode : req0_mode;
                        op_a    <= grant ? req1_a : req0_a;
                        op_b    <= grant ? req1_b : req0_b;
                        op_cin  <= grant
                            ? (req1_chain ? carry_flag[1] : req1_cin)
                            : (req0_chain ? carry_flag[0] : req0_cin);
                        op_id   <= grant;
                        last    <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_cb     <= alu_cb;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
                    rsp_zero   <= (alu_result == '0);
`endif
                    if (arith)
                        carry_flag[op_id] <= alu_cb;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed self-checking bench for alu_arb_ctrl at n=4.
module tb_alu_arb_ctrl;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_mode = 0, req1_mode = 0;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_cin = 0, req0_chain = 0, req1_cin = 0, req1_chain = 0;
    logic       rsp_valid, rsp_id, rsp_cb, busy;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_result;
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    int chk_cnt = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic [2:0] m;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       chain;
        logic [3:0] r;
        logic       cb;
    } vec_t;

    alu_arb_ctrl #(.n(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mode  (req0_mode),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_chain (req0_chain),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mode  (req1_mode),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_chain (req1_chain),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_cb     (rsp_cb),
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
        .rsp_zero   (rsp_zero),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Presents one request and returns in the cycle after its handshake
    task automatic issue(input logic id, input logic [2:0] m,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic chain);
        bit done = 0;
        if (id == 1'b0) begin
            req0_mode = m; req0_a = a; req0_b = b;
            req0_cin = cin; req0_chain = chain; req0_valid = 1'b1;
        end else begin
            req1_mode = m; req1_a = a; req1_b = b;
            req1_cin = cin; req1_chain = chain; req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 10 && !done; i++) begin
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready))
                done = 1;
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk_cnt++;
        if (!done)
            $display("FAIL handshake_timeout id=%0d got no ready within 10 cycles", id);
        else
            pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rsp_valid);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_id !== 1'b0) $display("FAIL rst_id got %b want 0", rsp_id);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_result !== 4'h0) $display("FAIL rst_result got %h want 0", rsp_result);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_cb !== 1'b0) $display("FAIL rst_cb got %b want 0", rsp_cb);
        else pass_cnt++;
        chk_cnt++;
        if (req0_ready !== 1'b0) $display("FAIL rst_ready0_idle got %b want 0", req0_ready);
        else pass_cnt++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk_cnt++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rst_first_tie got %b%b want 10", req0_ready, req1_ready);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_add_latency;
        issue(1'b0, MODE_ADD, 4'hF, 4'h1, 1'b0, 1'b0);
        chk_cnt++;
        if ({busy, rsp_valid} !== 2'b10)
            $display("FAIL lat_exec busy/valid got %b%b want 10", busy, rsp_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_cb} !== {1'b1, 1'b0, 4'h0, 1'b1})
            $display("FAIL lat_resp v/id/res/cb got %b/%b/%h/%b want 1/0/0/1",
                     rsp_valid, rsp_id, rsp_result, rsp_cb);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({busy, rsp_valid} !== 2'b00)
            $display("FAIL lat_idle busy/valid got %b%b want 00", busy, rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_arith;
        vec_t tbl [14];
        tbl[0]  = '{MODE_SUB, 4'h3, 4'h5, 1'b0, 1'b0, 4'hE, 1'b1};
        tbl[1]  = '{MODE_SUB, 4'h5, 4'h2, 1'b1, 1'b0, 4'h2, 1'b0};
        tbl[2]  = '{MODE_INC, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1};
        tbl[3]  = '{MODE_INC, 4'h6, 4'h0, 1'b0, 1'b0, 4'h7, 1'b0};
        tbl[4]  = '{MODE_DEC, 4'h0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
        tbl[5]  = '{MODE_AND, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 1'b0};
        tbl[6]  = '{MODE_OR,  4'hC, 4'hA, 1'b0, 1'b0, 4'hE, 1'b0};
        tbl[7]  = '{MODE_XOR, 4'hC, 4'hA, 1'b0, 1'b0, 4'h6, 1'b0};
        tbl[8]  = '{MODE_NOT, 4'h5, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0};
        tbl[9]  = '{MODE_ADD, 4'h3, 4'h4, 1'b1, 1'b0, 4'h8, 1'b0};
        tbl[10] = '{MODE_ADD, 4'h7, 4'h8, 1'b1, 1'b0, 4'h0, 1'b1};
        tbl[11] = '{MODE_AND, 4'hC, 4'hA, 1'b0, 1'b0, 4'h8, 1'b0};
        tbl[12] = '{MODE_ADD, 4'h0, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0};
        tbl[13] = '{MODE_ADD, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            issue(1'b0, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].chain);
            tick();
            chk_cnt++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_cb} !== {1'b1, 1'b0, tbl[i].r, tbl[i].cb})
                $display("FAIL arith[%0d] v/id/res/cb got %b/%b/%h/%b want 1/0/%h/%b",
                         i, rsp_valid, rsp_id, rsp_result, rsp_cb, tbl[i].r, tbl[i].cb);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_chain_req1;
        issue(1'b1, MODE_ADD, 4'hF, 4'h1, 1'b0, 1'b0);
        tick();
        chk_cnt++;
        if ({rsp_id, rsp_result, rsp_cb} !== {1'b1, 4'h0, 1'b1})
            $display("FAIL chain1_first id/res/cb got %b/%h/%b want 1/0/1",
                     rsp_id, rsp_result, rsp_cb);
        else pass_cnt++;
        tick();
        issue(1'b1, MODE_ADD, 4'h0, 4'h0, 1'b0, 1'b1);
        tick();
        chk_cnt++;
        if ({rsp_id, rsp_result, rsp_cb} !== {1'b1, 4'h1, 1'b0})
            $display("FAIL chain1_second id/res/cb got %b/%h/%b want 1/1/0",
                     rsp_id, rsp_result, rsp_cb);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0] want_rdy;
        do_reset();
        rsp_ready = 1'b1;
        req0_mode = MODE_ADD; req0_a = 4'h1; req0_b = 4'h1;
        req0_cin = 0; req0_chain = 0;
        req1_mode = MODE_ADD; req1_a = 4'h3; req1_b = 4'h4;
        req1_cin = 0; req1_chain = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int w = 0; w < 12; w++) begin
            want_rdy = 2'b00;
            if (w % 3 == 0)
                want_rdy = ((w / 3) % 2 == 0) ? 2'b10 : 2'b01;
            chk_cnt++;
            if ({req0_ready, req1_ready} !== want_rdy)
                $display("FAIL rr_ready w=%0d got %b%b want %b",
                         w, req0_ready, req1_ready, want_rdy);
            else pass_cnt++;
            if (w % 3 == 2) begin
                chk_cnt++;
                if (((w / 3) % 2 == 0) ?
                    ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 4'h2}) :
                    ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 4'h7}))
                    $display("FAIL rr_resp w=%0d v/id/res got %b/%b/%h",
                             w, rsp_valid, rsp_id, rsp_result);
                else pass_cnt++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        issue(1'b0, MODE_SUB, 4'h9, 4'h2, 1'b0, 1'b0);
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_cb, req0_ready, req1_ready, busy}
                !== {1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1})
                $display("FAIL bp_hold[%0d] v/id/res/cb/r0/r1/busy got %b/%b/%h/%b/%b/%b/%b want 1/0/7/0/0/0/1",
                         i, rsp_valid, rsp_id, rsp_result, rsp_cb,
                         req0_ready, req1_ready, busy);
            else pass_cnt++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk_cnt++;
        if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0001)
            $display("FAIL bp_release busy/v/r0/r1 got %b%b%b%b want 0001",
                     busy, rsp_valid, req0_ready, req1_ready);
        else pass_cnt++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_exec;
        bit seen = 0;
        issue(1'b0, MODE_ADD, 4'hF, 4'h1, 1'b0, 1'b0);
        tick();
        tick();
        issue(1'b0, MODE_ADD, 4'hF, 4'h1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({rsp_valid, busy} !== 2'b00)
            $display("FAIL midrst_async v/busy got %b%b want 00", rsp_valid, busy);
        else pass_cnt++;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid) seen = 1;
        end
        chk_cnt++;
        if (seen) $display("FAIL midrst_no_resp got a response want none");
        else pass_cnt++;
        issue(1'b0, MODE_ADD, 4'h0, 4'h0, 1'b0, 1'b1);
        tick();
        chk_cnt++;
        if ({rsp_result, rsp_cb} !== {4'h0, 1'b0})
            $display("FAIL midrst_flag_clear res/cb got %h/%b want 0/0",
                     rsp_result, rsp_cb);
        else pass_cnt++;
        tick();
    endtask

`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
    task automatic test_zero_flag;
        issue(1'b0, MODE_XOR, 4'h5, 4'h5, 1'b0, 1'b0);
        tick();
        chk_cnt++;
        if ({rsp_result, rsp_zero} !== {4'h0, 1'b1})
            $display("FAIL zero_set res/zero got %h/%b want 0/1", rsp_result, rsp_zero);
        else pass_cnt++;
        tick();
        issue(1'b0, MODE_XOR, 4'h5, 4'h4, 1'b0, 1'b0);
        tick();
        chk_cnt++;
        if ({rsp_result, rsp_zero} !== {4'h1, 1'b0})
            $display("FAIL zero_clr res/zero got %h/%b want 1/0", rsp_result, rsp_zero);
        else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_add_latency();
        test_arith();
        test_chain_req1();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_exec();
`ifdef ALU_ARB_CTRL_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
